// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch target buffer.
// Counter encodings, control-flow kind decode and saturating update.
package bp_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;

  typedef enum logic [1:0] {
    CK_NONE,
    CK_BRANCH,
    CK_JAL,
    CK_JALR
  } ctrl_kind_e;

  function automatic ctr_t sat_update(ctr_t c, logic taken);
    ctr_t r;
    r = c;
    if (taken) begin
      if (c != CTR_ST) r = c + 2'd1;
    end else begin
      if (c != CTR_SNT) r = c - 2'd1;
    end
    return r;
  endfunction

  // Overlapping flags are illegal; JALR > JAL > branch.
  function automatic ctrl_kind_e ctrl_kind(
    logic is_branch,
    logic is_jal,
    logic is_jalr
  );
    ctrl_kind_e k;
    k = CK_NONE;
    priority case (1'b1)
      is_jalr:   k = CK_JALR;
      is_jal:    k = CK_JAL;
      is_branch: k = CK_BRANCH;
      default:   k = CK_NONE;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/bp_target_resolve.sv
// Execute-side resolution of the control-flow target
// and the redirect decision against the carried prediction.
module bp_target_resolve
  import bp_pkg::*;
#(
  parameter int width_p = 32
) (
  input  ctrl_kind_e         kind_i,
  input  logic               valid_i,
  input  logic               taken_i,
  input  logic [width_p-1:0] pc_i,
  input  logic [width_p-1:0] imm_i,
  input  logic [width_p-1:0] alu_i,
  input  logic               pred_taken_i,
  input  logic [width_p-1:0] pred_target_i,
  output logic [width_p-1:0] target_o,
  output logic               taken_eff_o,
  output logic               mispredict_o
);

  always_comb begin
    target_o    = pc_i + width_p'(4);
    taken_eff_o = 1'b0;
    unique case (kind_i)
      CK_JALR: begin
        target_o    = alu_i & ~width_p'(1);
        taken_eff_o = 1'b1;
      end
      CK_JAL: begin
        target_o    = pc_i + imm_i;
        taken_eff_o = 1'b1;
      end
      CK_BRANCH: begin
        target_o    = pc_i + imm_i;
        taken_eff_o = taken_i;
      end
      default: begin
        target_o    = pc_i + width_p'(4);
        taken_eff_o = 1'b0;
      end
    endcase
  end

  always_comb begin
    mispredict_o = 1'b0;
    if (valid_i) begin
      mispredict_o = (taken_eff_o != pred_taken_i)
                   || (taken_eff_o
                       && (target_o != pred_target_i));
    end
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with 2-bit counters: fetch-side lookup,
// execute-side resolve and one-cycle-latency training.
module branch_predictor_btb
  import bp_pkg::*;
#(
  parameter int width_p   = 32,
  parameter int entries_p = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic [width_p-1:0] fetch_pc_i,
  output logic               pred_hit_o,
  output logic               pred_taken_o,
  output logic [width_p-1:0] pred_target_o,
  input  logic               upd_valid_i,
  input  logic               upd_is_branch_i,
  input  logic               upd_is_jal_i,
  input  logic               upd_is_jalr_i,
  input  logic               upd_taken_i,
  input  logic [width_p-1:0] upd_pc_i,
  input  logic [width_p-1:0] upd_immediate_i,
  input  logic [width_p-1:0] upd_alu_result_i,
  input  logic               upd_pred_taken_i,
  input  logic [width_p-1:0] upd_pred_target_i,
  output logic [width_p-1:0] upd_target_o,
  output logic               upd_mispredict_o
);

  localparam int idx_w_lp = $clog2(entries_p);
  localparam int tag_w_lp = width_p - 2 - idx_w_lp;

  logic [entries_p-1:0] valid_q;
  logic [entries_p-1:0] unc_q;
  logic [tag_w_lp-1:0]  tag_q [entries_p];
  logic [width_p-1:0]   tgt_q [entries_p];
  ctr_t                 ctr_q [entries_p];

  logic [idx_w_lp-1:0] f_idx;
  logic [tag_w_lp-1:0] f_tag;
  logic [idx_w_lp-1:0] u_idx;
  logic [tag_w_lp-1:0] u_tag;
  logic                u_hit;
  logic                taken_eff;
  ctrl_kind_e          kind;

  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{fetch_pc_i[1:0], upd_pc_i[1:0],
                            taken_eff};

  assign f_idx = fetch_pc_i[idx_w_lp+1:2];
  assign f_tag = fetch_pc_i[width_p-1:idx_w_lp+2];
  assign u_idx = upd_pc_i[idx_w_lp+1:2];
  assign u_tag = upd_pc_i[width_p-1:idx_w_lp+2];

  // Lookup sees only registered state; no bypass from updates.
  always_comb begin
    pred_hit_o    = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    pred_taken_o  = pred_hit_o
                  && (unc_q[f_idx] || ctr_q[f_idx][1]);
    pred_target_o = pred_taken_o ? tgt_q[f_idx]
                                 : fetch_pc_i + width_p'(4);
  end

  assign kind  = ctrl_kind(upd_is_branch_i, upd_is_jal_i,
                           upd_is_jalr_i);
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  bp_target_resolve #(
    .width_p(width_p)
  ) u_resolve (
    .kind_i       (kind),
    .valid_i      (upd_valid_i),
    .taken_i      (upd_taken_i),
    .pc_i         (upd_pc_i),
    .imm_i        (upd_immediate_i),
    .alu_i        (upd_alu_result_i),
    .pred_taken_i (upd_pred_taken_i),
    .pred_target_i(upd_pred_target_i),
    .target_o     (upd_target_o),
    .taken_eff_o  (taken_eff),
    .mispredict_o (upd_mispredict_o)
  );

  logic                we;
  logic                n_valid;
  logic                n_unc;
  logic [tag_w_lp-1:0] n_tag;
  logic [width_p-1:0]  n_tgt;
  ctr_t                n_ctr;

  always_comb begin
    we      = 1'b0;
    n_valid = valid_q[u_idx];
    n_unc   = unc_q[u_idx];
    n_tag   = tag_q[u_idx];
    n_tgt   = tgt_q[u_idx];
    n_ctr   = ctr_q[u_idx];
    if (upd_valid_i) begin
      unique case (kind)
        CK_BRANCH: begin
          if (u_hit) begin
            we    = 1'b1;
            n_ctr = sat_update(ctr_q[u_idx], upd_taken_i);
            if (upd_taken_i) n_tgt = upd_target_o;
          end else if (upd_taken_i) begin
            we      = 1'b1;
            n_valid = 1'b1;
            n_tag   = u_tag;
            n_tgt   = upd_target_o;
            n_ctr   = CTR_WT;
            n_unc   = 1'b0;
          end
        end
        CK_JAL, CK_JALR: begin
          we      = 1'b1;
          n_valid = 1'b1;
          n_tag   = u_tag;
          n_tgt   = upd_target_o;
          n_ctr   = CTR_ST;
          n_unc   = 1'b1;
        end
        default: begin
          // A non-control hit means the entry aliases stale code.
          if (u_hit) begin
            we      = 1'b1;
            n_valid = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      unc_q   <= '0;
      for (int i = 0; i < entries_p; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= CTR_WNT;
      end
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[u_idx] <= n_valid;
      unc_q[u_idx]   <= n_unc;
      tag_q[u_idx]   <= n_tag;
      tgt_q[u_idx]   <= n_tgt;
      ctr_q[u_idx]   <= n_ctr;
    end
  end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Randomised bench for branch_predictor_btb against an
// entry-level behavioural model, plus directed literal checks.
module tb_branch_predictor_btb;

  logic        clk;
  logic        rst_ni;
  logic        flush_i;
  logic [31:0] fetch_pc_i;
  logic        pred_hit_o;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        upd_valid_i;
  logic        upd_is_branch_i;
  logic        upd_is_jal_i;
  logic        upd_is_jalr_i;
  logic        upd_taken_i;
  logic [31:0] upd_pc_i;
  logic [31:0] upd_immediate_i;
  logic [31:0] upd_alu_result_i;
  logic        upd_pred_taken_i;
  logic [31:0] upd_pred_target_i;
  logic [31:0] upd_target_o;
  logic        upd_mispredict_o;

  int checks = 0;
  int errors = 0;

  branch_predictor_btb #(
    .width_p  (32),
    .entries_p(16)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .flush_i          (flush_i),
    .fetch_pc_i       (fetch_pc_i),
    .pred_hit_o       (pred_hit_o),
    .pred_taken_o     (pred_taken_o),
    .pred_target_o    (pred_target_o),
    .upd_valid_i      (upd_valid_i),
    .upd_is_branch_i  (upd_is_branch_i),
    .upd_is_jal_i     (upd_is_jal_i),
    .upd_is_jalr_i    (upd_is_jalr_i),
    .upd_taken_i      (upd_taken_i),
    .upd_pc_i         (upd_pc_i),
    .upd_immediate_i  (upd_immediate_i),
    .upd_alu_result_i (upd_alu_result_i),
    .upd_pred_taken_i (upd_pred_taken_i),
    .upd_pred_target_i(upd_pred_target_i),
    .upd_target_o     (upd_target_o),
    .upd_mispredict_o (upd_mispredict_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: one record per entry, counter as 0..3.
  bit          m_valid [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  bit          m_unc   [16];

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  function automatic logic [31:0] tag_of(logic [31:0] pc);
    return pc >> 6;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0;
      m_tag[i]   = 0;
      m_tgt[i]   = 0;
      m_ctr[i]   = 1;
      m_unc[i]   = 0;
    end
  endfunction

  function automatic void model_pred(
    input  logic [31:0] pc,
    output bit          hit,
    output bit          tk,
    output logic [31:0] tgt
  );
    int i;
    i   = idx_of(pc);
    hit = m_valid[i] && (m_tag[i] == tag_of(pc));
    tk  = hit && (m_unc[i] || m_ctr[i] >= 2);
    tgt = tk ? m_tgt[i] : pc + 32'd4;
  endfunction

  function automatic logic [31:0] model_target();
    if (upd_is_jalr_i)
      return upd_alu_result_i & 32'hFFFF_FFFE;
    if (upd_is_jal_i || upd_is_branch_i)
      return upd_pc_i + upd_immediate_i;
    return upd_pc_i + 32'd4;
  endfunction

  function automatic bit model_mis();
    bit te;
    logic [31:0] t;
    if (!upd_valid_i) return 0;
    te = upd_is_jal_i || upd_is_jalr_i
       || (upd_is_branch_i && upd_taken_i);
    t  = model_target();
    return (te != upd_pred_taken_i)
        || (te && t != upd_pred_target_i);
  endfunction

  function automatic void model_clock();
    int i;
    bit hit;
    logic [31:0] t;
    if (flush_i) begin
      for (int k = 0; k < 16; k++) m_valid[k] = 0;
      return;
    end
    if (!upd_valid_i) return;
    i   = idx_of(upd_pc_i);
    hit = m_valid[i] && (m_tag[i] == tag_of(upd_pc_i));
    t   = model_target();
    if (upd_is_jalr_i || upd_is_jal_i) begin
      m_valid[i] = 1;
      m_tag[i]   = tag_of(upd_pc_i);
      m_tgt[i]   = t;
      m_ctr[i]   = 3;
      m_unc[i]   = 1;
    end else if (upd_is_branch_i) begin
      if (hit) begin
        if (upd_taken_i) begin
          m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
          m_tgt[i] = t;
        end else begin
          m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end
      end else if (upd_taken_i) begin
        m_valid[i] = 1;
        m_tag[i]   = tag_of(upd_pc_i);
        m_tgt[i]   = t;
        m_ctr[i]   = 2;
        m_unc[i]   = 0;
      end
    end else if (hit) begin
      m_valid[i] = 0;
    end
  endfunction

  task automatic cmp(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h want %h",
               name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    bit hit, tk;
    logic [31:0] tgt;
    model_pred(fetch_pc_i, hit, tk, tgt);
    cmp("pred_hit", 32'(pred_hit_o), 32'(hit));
    cmp("pred_taken", 32'(pred_taken_o), 32'(tk));
    cmp("pred_target", pred_target_o, tgt);
    cmp("upd_target", upd_target_o, model_target());
    cmp("upd_mispredict", 32'(upd_mispredict_o),
        32'(model_mis()));
  endtask

  // Compare at negedge, then advance model and DUT one edge.
  task automatic cycle();
    @(negedge clk);
    check_model();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic idle_upd();
    upd_valid_i       = 0;
    upd_is_branch_i   = 0;
    upd_is_jal_i      = 0;
    upd_is_jalr_i     = 0;
    upd_taken_i       = 0;
    upd_pc_i          = 0;
    upd_immediate_i   = 0;
    upd_alu_result_i  = 0;
    upd_pred_taken_i  = 0;
    upd_pred_target_i = 0;
  endtask

  task automatic set_upd(bit br, bit jal, bit jalr, bit tk,
                         logic [31:0] pc, logic [31:0] imm,
                         logic [31:0] alu, bit ptk,
                         logic [31:0] ptgt);
    upd_valid_i       = 1;
    upd_is_branch_i   = br;
    upd_is_jal_i      = jal;
    upd_is_jalr_i     = jalr;
    upd_taken_i       = tk;
    upd_pc_i          = pc;
    upd_immediate_i   = imm;
    upd_alu_result_i  = alu;
    upd_pred_taken_i  = ptk;
    upd_pred_target_i = ptgt;
  endtask

  function automatic logic [31:0] pool_pc();
    logic [31:0] p;
    p = ($urandom_range(0, 2) << 6)
      | ($urandom_range(0, 7) << 2);
    return p;
  endfunction

  initial begin
    rst_ni     = 0;
    flush_i    = 0;
    fetch_pc_i = 32'h100;
    idle_upd();
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst_ni = 1;
    @(posedge clk);
    #1;

    // Reset state.
    fetch_pc_i = 32'h100;
    #1;
    cmp("rst_hit", 32'(pred_hit_o), 32'h0);
    cmp("rst_taken", 32'(pred_taken_o), 32'h0);
    cmp("rst_target", pred_target_o, 32'h104);
    cycle();

    // Taken branch allocates with weakly-taken counter.
    set_upd(1, 0, 0, 1, 32'h100, 32'h40, 0, 0, 32'h104);
    #1;
    cmp("br_target", upd_target_o, 32'h140);
    cmp("br_mis", 32'(upd_mispredict_o), 32'h1);
    cycle();
    idle_upd();
    #1;
    cmp("br_hit", 32'(pred_hit_o), 32'h1);
    cmp("br_taken", 32'(pred_taken_o), 32'h1);
    cmp("br_ptgt", pred_target_o, 32'h140);
    cycle();

    // Two not-taken resolutions: 10 -> 01 -> 00.
    set_upd(1, 0, 0, 0, 32'h100, 32'h40, 0, 1, 32'h140);
    #1;
    cmp("nt_mis", 32'(upd_mispredict_o), 32'h1);
    cycle();
    set_upd(1, 0, 0, 0, 32'h100, 32'h40, 0, 0, 32'h104);
    #1;
    cmp("nt_mis2", 32'(upd_mispredict_o), 32'h0);
    cycle();
    idle_upd();
    #1;
    cmp("snt_taken", 32'(pred_taken_o), 32'h0);
    cmp("snt_target", pred_target_o, 32'h104);
    cycle();
    set_upd(1, 0, 0, 1, 32'h100, 32'h40, 0, 0, 32'h104);
    cycle();
    idle_upd();
    #1;
    cmp("wnt_hit", 32'(pred_hit_o), 32'h1);
    cmp("wnt_taken", 32'(pred_taken_o), 32'h0);
    cycle();

    // JALR clears bit 0 and marks the entry unconditional.
    set_upd(0, 0, 1, 0, 32'h200, 32'h0, 32'h1235, 0, 0);
    #1;
    cmp("jalr_target", upd_target_o, 32'h1234);
    cycle();
    idle_upd();
    fetch_pc_i = 32'h200;
    #1;
    cmp("jalr_taken", 32'(pred_taken_o), 32'h1);
    cmp("jalr_ptgt", pred_target_o, 32'h1234);
    cycle();
    fetch_pc_i = 32'h600;
    #1;
    cmp("alias_hit", 32'(pred_hit_o), 32'h0);
    cycle();

    // Same-index update and lookup: no bypass.
    fetch_pc_i = 32'h100;
    set_upd(0, 1, 0, 0, 32'h100, 32'h20, 0, 0, 32'h104);
    #1;
    cmp("nobyp_hit", 32'(pred_hit_o), 32'h0);
    cmp("nobyp_tgt", pred_target_o, 32'h104);
    cycle();
    idle_upd();
    #1;
    cmp("after_taken", 32'(pred_taken_o), 32'h1);
    cmp("after_tgt", pred_target_o, 32'h120);
    cycle();

    // Flush wins over a simultaneous update.
    flush_i = 1;
    set_upd(0, 1, 0, 0, 32'h300, 32'h8, 0, 0, 0);
    cycle();
    flush_i = 0;
    idle_upd();
    fetch_pc_i = 32'h300;
    #1;
    cmp("flush_hit_300", 32'(pred_hit_o), 32'h0);
    cycle();
    fetch_pc_i = 32'h100;
    #1;
    cmp("flush_hit_100", 32'(pred_hit_o), 32'h0);
    cycle();

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      int r;
      bit hit, tk;
      logic [31:0] tgt;
      fetch_pc_i = pool_pc();
      flush_i    = ($urandom_range(0, 63) == 0);
      idle_upd();
      if ($urandom_range(0, 3) != 0) begin
        upd_valid_i = 1;
        r = $urandom_range(0, 15);
        if (r <= 5) upd_is_branch_i = 1;
        else if (r <= 8) upd_is_jal_i = 1;
        else if (r <= 10) upd_is_jalr_i = 1;
        else if (r == 11) begin
          upd_is_branch_i = 1'($urandom);
          upd_is_jal_i    = 1;
          upd_is_jalr_i   = 1'($urandom);
        end
        upd_taken_i      = 1'($urandom);
        upd_pc_i         = pool_pc();
        upd_immediate_i  = 32'($urandom_range(0, 63) * 4) - 32'd128;
        upd_alu_result_i = $urandom;
        if ($urandom_range(0, 1) == 0) begin
          model_pred(upd_pc_i, hit, tk, tgt);
          upd_pred_taken_i  = tk;
          upd_pred_target_i = tgt;
        end else begin
          upd_pred_taken_i  = 1'($urandom);
          upd_pred_target_i = $urandom_range(0, 1)
                            ? upd_pc_i + upd_immediate_i
                            : $urandom;
        end
      end
      cycle();
    end
    flush_i = 0;
    idle_upd();

    // Asynchronous reset between edges.
    set_upd(0, 1, 0, 0, 32'h300, 32'h8, 0, 0, 0);
    cycle();
    idle_upd();
    fetch_pc_i = 32'h300;
    #1;
    cmp("pre_rst_hit", 32'(pred_hit_o), 32'h1);
    #1 rst_ni = 0;
    #1;
    cmp("async_rst_hit", 32'(pred_hit_o), 32'h0);
    cmp("async_rst_tgt", pred_target_o, 32'h304);
    model_reset();
    @(negedge clk);
    #2 rst_ni = 1;
    @(posedge clk);
    #1;
    for (int n = 0; n < 24; n++) begin
      fetch_pc_i = pool_pc();
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout @%0t: got running want done", $time);
    $fatal(1, "timeout");
  end

endmodule
